// File: rtl/score_uart_reporter_if.sv
// Game-status inputs and UART TX handshake shared between the status
// reporter (slave) and the control/UART side (master).
interface score_uart_reporter_if;
  logic        start;
  logic        over;
  logic [15:0] score;
  logic        score_inc;
  logic        is_transmitting;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        busy;

  modport slave (
    input  start, over, score, score_inc, is_transmitting,
    output transmit, tx_byte, busy
  );

  modport master (
    output start, over, score, score_inc, is_transmitting,
    input  transmit, tx_byte, busy
  );
endinterface

// File: rtl/score_uart_reporter.sv
// Watches game start/over/score events and streams short ASCII status lines
// (GO, S=dddd, END dddd) through the shared UART transmit handshake.
module score_uart_reporter #(
  parameter int TIMEOUT  = 4096,
  parameter bit EN_SCORE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  score_uart_reporter_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_SEND      = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_NEXT      = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    M_GO    = 2'd0,
    M_SCORE = 2'd1,
    M_END   = 2'd2
  } msg_t;

  function automatic logic [7:0] bcd_char(input logic [3:0] nib);
    if (nib > 4'd9) bcd_char = 8'h3F;
    else            bcd_char = 8'h30 + {4'h0, nib};
  endfunction

  function automatic logic [3:0] msg_last(input msg_t m);
    case (m)
      M_GO:    msg_last = 4'd3;
      M_SCORE: msg_last = 4'd7;
      default: msg_last = 4'd9;
    endcase
  endfunction

  function automatic logic [7:0] msg_byte(input msg_t m, input logic [3:0] idx,
                                          input logic [15:0] s);
    msg_byte = 8'h00;
    case (m)
      M_GO: begin
        case (idx)
          4'd0:    msg_byte = 8'h47;
          4'd1:    msg_byte = 8'h4F;
          4'd2:    msg_byte = 8'h0D;
          default: msg_byte = 8'h0A;
        endcase
      end
      M_SCORE: begin
        case (idx)
          4'd0:    msg_byte = 8'h53;
          4'd1:    msg_byte = 8'h3D;
          4'd2:    msg_byte = bcd_char(s[15:12]);
          4'd3:    msg_byte = bcd_char(s[11:8]);
          4'd4:    msg_byte = bcd_char(s[7:4]);
          4'd5:    msg_byte = bcd_char(s[3:0]);
          4'd6:    msg_byte = 8'h0D;
          default: msg_byte = 8'h0A;
        endcase
      end
      default: begin
        case (idx)
          4'd0:    msg_byte = 8'h45;
          4'd1:    msg_byte = 8'h4E;
          4'd2:    msg_byte = 8'h44;
          4'd3:    msg_byte = 8'h20;
          4'd4:    msg_byte = bcd_char(s[15:12]);
          4'd5:    msg_byte = bcd_char(s[11:8]);
          4'd6:    msg_byte = bcd_char(s[7:4]);
          4'd7:    msg_byte = bcd_char(s[3:0]);
          4'd8:    msg_byte = 8'h0D;
          default: msg_byte = 8'h0A;
        endcase
      end
    endcase
  endfunction

  state_t          state_q, state_d;
  msg_t            msg_q, msg_d;
  logic [15:0]     snap_q, snap_d;
  logic [3:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            prev_start_q, prev_start_d;
  logic            prev_over_q, prev_over_d;
  logic            p_go_q, p_go_d;
  logic            p_score_q, p_score_d;
  logic            p_end_q, p_end_d;
  logic            transmit_o, busy_o;
  logic            start_ev, over_ev;

  assign start_ev = bus.start & ~prev_start_q;
  assign over_ev  = bus.over  & ~prev_over_q;

  // State register and all datapath flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      msg_q        <= M_GO;
      snap_q       <= 16'h0000;
      idx_q        <= 4'd0;
      cnt_q        <= {CW{1'b0}};
      tx_byte_q    <= 8'h00;
      prev_start_q <= 1'b0;
      prev_over_q  <= 1'b0;
      p_go_q       <= 1'b0;
      p_score_q    <= 1'b0;
      p_end_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      msg_q        <= msg_d;
      snap_q       <= snap_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      tx_byte_q    <= tx_byte_d;
      prev_start_q <= prev_start_d;
      prev_over_q  <= prev_over_d;
      p_go_q       <= p_go_d;
      p_score_q    <= p_score_d;
      p_end_q      <= p_end_d;
    end
  end

  // Next-state, message sequencing and pending-flag bookkeeping
  always_comb begin
    state_d      = state_q;
    msg_d        = msg_q;
    snap_d       = snap_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    tx_byte_d    = tx_byte_q;
    prev_start_d = bus.start;
    prev_over_d  = bus.over;
    p_go_d       = p_go_q;
    p_score_d    = p_score_q;
    p_end_d      = p_end_q;

    case (state_q)
      S_IDLE: begin
        if (p_go_q | p_score_q | p_end_q) state_d = S_LOAD;
        else                              state_d = S_IDLE;
      end
      S_LOAD: begin
        if (p_go_q) begin
          msg_d  = M_GO;
          p_go_d = 1'b0;
        end else if (p_score_q) begin
          msg_d     = M_SCORE;
          p_score_d = 1'b0;
        end else begin
          msg_d   = M_END;
          p_end_d = 1'b0;
        end
        snap_d    = bus.score;
        idx_d     = 4'd0;
        tx_byte_d = msg_byte(msg_d, 4'd0, bus.score);
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (!bus.is_transmitting) begin
          cnt_d   = {CW{1'b0}};
          state_d = S_WAIT_BUSY;
        end else begin
          state_d = S_SEND;
        end
      end
      S_WAIT_BUSY: begin
        if (bus.is_transmitting) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_NEXT;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.is_transmitting) state_d = S_NEXT;
        else                      state_d = S_WAIT_DONE;
      end
      S_NEXT: begin
        if (idx_q >= msg_last(msg_q)) begin
          state_d = S_IDLE;
        end else begin
          idx_d     = idx_q + 4'd1;
          tx_byte_d = msg_byte(msg_q, idx_q + 4'd1, snap_q);
          state_d   = S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Events are applied after the LOAD clear so one arriving that cycle is kept
    if (start_ev) begin
      p_go_d    = 1'b1;
      p_score_d = 1'b0;
      p_end_d   = 1'b0;
    end else begin
      if (bus.score_inc && EN_SCORE) p_score_d = 1'b1;
      else                           p_score_d = p_score_d;
      if (over_ev) begin
        p_end_d   = 1'b1;
        p_score_d = 1'b0;
      end else begin
        p_end_d = p_end_d;
      end
    end
  end

  // Output decode; transmit is gated by the live busy flag so it never overlaps it
  always_comb begin
    transmit_o = 1'b0;
    if ((state_q == S_SEND) && !bus.is_transmitting) transmit_o = 1'b1;
    else                                             transmit_o = 1'b0;
    busy_o = (state_q != S_IDLE);
  end

  assign bus.transmit = transmit_o;
  assign bus.tx_byte  = tx_byte_q;
  assign bus.busy     = busy_o;
endmodule

// File: tb/tb_score_uart_reporter.sv
// Scoreboard bench for score_uart_reporter: stimulus pushes expected bytes,
// monitors pop and compare on every transmit pulse.
module tb_score_uart_reporter;
  logic clk;
  logic rst_a;
  logic rst_b;

  score_uart_reporter_if if_a ();
  score_uart_reporter_if if_b ();

  score_uart_reporter #(.TIMEOUT(8), .EN_SCORE(1'b1)) dut_a (
    .clk(clk), .reset(rst_a), .bus(if_a)
  );
  score_uart_reporter #(.TIMEOUT(8), .EN_SCORE(1'b0)) dut_b (
    .clk(clk), .reset(rst_b), .bus(if_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int n_pulse_a = 0;
  int n_pulse_b = 0;
  int first_cyc_a = -1;
  int last_cyc_a = -1;
  bit gap_chk_a = 1'b0;
  bit no_busy_a = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_str(input int which, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (which == 0) q_a.push_back(s[i]);
      else            q_b.push_back(s[i]);
    end
  endtask

  task automatic wait_idle_a(input int maxc);
    int n;
    n = 0;
    while ((q_a.size() != 0 || if_a.busy) && n < maxc) begin
      tick(1);
      n++;
    end
    chk("idle_a", int'(q_a.size() == 0 && !if_a.busy), 1);
  endtask

  task automatic wait_idle_b(input int maxc);
    int n;
    n = 0;
    while ((q_b.size() != 0 || if_b.busy) && n < maxc) begin
      tick(1);
      n++;
    end
    chk("idle_b", int'(q_b.size() == 0 && !if_b.busy), 1);
  endtask

  task automatic wait_pulses_a(input int target, input int maxc);
    int n;
    n = 0;
    while (n_pulse_a < target && n < maxc) begin
      tick(1);
      n++;
    end
    chk("pulse_reached_a", int'(n_pulse_a >= target), 1);
  endtask

  // UART model for A: busy one cycle after each pulse, for 10 cycles
  initial begin
    if_a.is_transmitting = 1'b0;
    forever begin
      @(negedge clk);
      if (if_a.transmit && !no_busy_a) begin
        @(posedge clk);
        #1;
        if_a.is_transmitting = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        if_a.is_transmitting = 1'b0;
      end
    end
  end

  // Monitor A
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (if_a.transmit) begin
        n_pulse_a++;
        chk("tx_while_busy_a", int'(if_a.is_transmitting), 0);
        if (q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte_a: got %02h, expected no byte (cycle %0d)",
                   if_a.tx_byte, cyc);
        end else begin
          exp_b = q_a.pop_front();
          chk("byte_a", int'(if_a.tx_byte), int'(exp_b));
        end
        if (first_cyc_a >= 0) begin
          chk("first_pulse_cycle_a", cyc, first_cyc_a);
          first_cyc_a = -1;
        end
        if (gap_chk_a && last_cyc_a >= 0) chk("timeout_gap_a", cyc - last_cyc_a, 10);
        last_cyc_a = cyc;
      end
    end
  end

  // Monitor B
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (if_b.transmit) begin
        n_pulse_b++;
        if (q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte_b: got %02h, expected no byte (cycle %0d)",
                   if_b.tx_byte, cyc);
        end else begin
          exp_b = q_b.pop_front();
          chk("byte_b", int'(if_b.tx_byte), int'(exp_b));
        end
      end
    end
  end

  initial begin
    int base;
    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.start = 1'b0; if_a.over = 1'b0; if_a.score = 16'h0000; if_a.score_inc = 1'b0;
    if_b.start = 1'b0; if_b.over = 1'b0; if_b.score = 16'h0000; if_b.score_inc = 1'b0;
    if_b.is_transmitting = 1'b0;
    tick(3);
    chk("reset_transmit_a", int'(if_a.transmit), 0);
    chk("reset_tx_byte_a", int'(if_a.tx_byte), 0);
    chk("reset_busy_a", int'(if_a.busy), 0);
    chk("reset_transmit_b", int'(if_b.transmit), 0);
    chk("reset_tx_byte_b", int'(if_b.tx_byte), 0);
    chk("reset_busy_b", int'(if_b.busy), 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick(2);

    // Single GO line, first pulse two cycles after the sampling edge
    base = n_pulse_a;
    if_a.start = 1'b1;
    push_str(0, "GO\r\n");
    first_cyc_a = cyc + 3;
    wait_idle_a(300);
    chk("go_count", n_pulse_a - base, 4);
    if_a.start = 1'b0;
    tick(5);

    // Score snapshot: later score change must not leak into the line
    base = n_pulse_a;
    if_a.score = 16'h0123;
    if_a.score_inc = 1'b1;
    push_str(0, "S=0123\r\n");
    tick(1);
    if_a.score_inc = 1'b0;
    wait_pulses_a(base + 2, 200);
    if_a.score = 16'h0456;
    wait_idle_a(300);
    tick(40);
    chk("score_line_count", n_pulse_a - base, 8);

    // Coalesced score pulses superseded by END
    base = n_pulse_a;
    if_a.start = 1'b1;
    push_str(0, "GO\r\n");
    tick(3);
    for (int i = 0; i < 3; i++) begin
      if_a.score_inc = 1'b1;
      tick(1);
      if_a.score_inc = 1'b0;
      tick(1);
    end
    if_a.score = 16'h0042;
    if_a.over = 1'b1;
    push_str(0, "END 0042\r\n");
    wait_idle_a(600);
    tick(30);
    chk("go_end_count", n_pulse_a - base, 14);
    if_a.start = 1'b0;
    if_a.over = 1'b0;
    tick(5);

    // Timeout: UART never goes busy
    no_busy_a = 1'b1;
    last_cyc_a = -1;
    gap_chk_a = 1'b1;
    base = n_pulse_a;
    if_a.start = 1'b1;
    push_str(0, "GO\r\n");
    wait_idle_a(200);
    chk("timeout_go_count", n_pulse_a - base, 4);
    gap_chk_a = 1'b0;
    no_busy_a = 1'b0;
    if_a.start = 1'b0;
    tick(5);

    // Async reset during the third byte of a SCORE line
    base = n_pulse_a;
    if_a.score = 16'h0789;
    if_a.score_inc = 1'b1;
    push_str(0, "S=0");
    tick(1);
    if_a.score_inc = 1'b0;
    wait_pulses_a(base + 3, 200);
    tick(3);
    #2;
    chk("busy_before_reset", int'(if_a.busy), 1);
    rst_a = 1'b1;
    #1;
    chk("reset_mid_transmit", int'(if_a.transmit), 0);
    chk("reset_mid_busy", int'(if_a.busy), 0);
    chk("reset_mid_tx_byte", int'(if_a.tx_byte), 0);
    tick(3);
    rst_a = 1'b0;
    tick(80);
    chk("no_resume_count", n_pulse_a - base, 3);
    chk("no_resume_busy", int'(if_a.busy), 0);
    chk("no_resume_queue", q_a.size(), 0);

    // EN_SCORE=0 ignores score_inc; invalid BCD digit shown as '?'
    if_b.score = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      if_b.score_inc = 1'b1;
      tick(1);
      if_b.score_inc = 1'b0;
      tick(2);
    end
    tick(30);
    chk("en_score_off_pulses", n_pulse_b, 0);
    chk("en_score_off_busy", int'(if_b.busy), 0);
    if_b.score = 16'h0A00;
    if_b.over = 1'b1;
    push_str(1, "END 0?00\r\n");
    wait_idle_b(400);
    chk("end_invalid_count", n_pulse_b, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
